// File: rtl/fuzz_stim_misr.sv
// Self-contained stimulus generator and response compactor: a seeded LFSR drives NUM_VEC vectors,
// the delayed responses fold into a MISR and the final signature is compared against exp_sig.
module fuzz_stim_misr #(
    parameter int               IN_W      = 256,
    parameter int               OUT_W     = 81,
    parameter int               NUM_VEC   = 21,
    parameter int               RESP_LAT  = 1,
    parameter logic [31:0]      SEED      = 32'h00000001,
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(1),
    parameter logic [OUT_W-1:0] SIG_INIT  = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hold,
    input  logic [OUT_W-1:0] resp_in,
    input  logic [OUT_W-1:0] exp_sig,
    output logic [IN_W-1:0]  stim_out,
    output logic             stim_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] sig_out,
    output logic [CNT_W-1:0] vec_cnt
);

    localparam int               K         = (IN_W + 31) / 32;
    localparam int               PW        = (RESP_LAT == 0) ? 1 : RESP_LAT;
    localparam logic [31:0]      SEED_FIX  = (SEED == 32'h0) ? 32'h00000001 : SEED;
    localparam logic [31:0]      LFSR_TAPS = 32'h80200003;
    localparam logic [31:0]      GOLDEN    = 32'h9E3779B9;
    localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [31:0]       lfsr_q;
    logic [31:0]       lfsr_d;
    logic [IN_W-1:0]   stim_q;
    logic [IN_W-1:0]   stim_d;
    logic              stim_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [OUT_W-1:0]  sig_q;
    logic [OUT_W-1:0]  sig_d;
    logic [CNT_W-1:0]  vec_cnt_q;
    logic [CNT_W-1:0]  cap_cnt_q;
    logic [PW-1:0]     pipe_q;
    logic [PW:0]       pipe_ext_s;
    logic              cap_v_s;

    // Each 32-bit word is the LFSR state whitened by a distinct multiple of the golden ratio.
    function automatic logic [IN_W-1:0] stim_map(input logic [31:0] s);
        logic [K*32-1:0] w;
        w = '0;
        for (int k = 0; k < K; k++) begin
            w[k*32 +: 32] = s ^ (32'(k) * GOLDEN);
        end
        return w[IN_W-1:0];
    endfunction

    // Next-state values for the LFSR, stimulus word, capture strobe and MISR.
    always_comb begin
        lfsr_d     = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        stim_d     = stim_map(lfsr_q);
        pipe_ext_s = {pipe_q, stim_valid_q};
        cap_v_s    = pipe_ext_s[RESP_LAT];
        sig_d      = {sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? MISR_POLY : '0) ^ resp_in;
    end

    // Run controller, capture pipeline and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED_FIX;
            stim_q       <= '0;
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            sig_q        <= SIG_INIT;
            vec_cnt_q    <= '0;
            cap_cnt_q    <= '0;
            pipe_q       <= '0;
        end else begin
            pipe_q       <= pipe_ext_s[PW-1:0];
            stim_valid_q <= 1'b0;
            if (cap_v_s) begin
                sig_q     <= sig_d;
                cap_cnt_q <= cap_cnt_q + CNT_W'(1);
            end
            // A (re)start overrides any capture landing on the same edge.
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr_q    <= SEED_FIX;
                        sig_q     <= SIG_INIT;
                        vec_cnt_q <= '0;
                        cap_cnt_q <= '0;
                        pipe_q    <= '0;
                        if (NUM_VEC == 0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (SIG_INIT == exp_sig);
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (!hold) begin
                        stim_q       <= stim_d;
                        stim_valid_q <= 1'b1;
                        lfsr_q       <= lfsr_d;
                        vec_cnt_q    <= vec_cnt_q + CNT_W'(1);
                        if (vec_cnt_q + CNT_W'(1) == NUM_VEC_C) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cap_cnt_q == NUM_VEC_C) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (sig_q == exp_sig);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign stim_out   = stim_q;
    assign stim_valid = stim_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign sig_out    = sig_q;
    assign vec_cnt    = vec_cnt_q;

endmodule
